multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32I core.
// Each instruction is sequenced over several states. The FSM drives the
// shared ALU, memory and register-file controls, and it waits on a
// variable-latency memory handshake. It also counts retired instructions.
//
// Handshake: mem_req is held high for as long as an access is outstanding.
// The access completes in the cycle where mem_req=1 and mem_ready=1. Only
// in that cycle do IRWrite/PCUpdate (fetch) and MemWrite/retire (store)
// assert. With MEM_HS=0, mem_ready is ignored and every access completes
// in one cycle.
//
// Optional feature macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
// When it is defined, an unknown opcode locks the FSM in TRAP and raises
// illegal_op. When it is undefined, an unknown opcode simply returns to FETCH.
module multicycle_ctrl #(
  parameter int CNT_W  = 32,
  parameter bit MEM_HS = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             PCUpdate,
  output logic             Branch,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ResultSrc,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ALUOp,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal_op
);

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t state, next;
  logic   rdy;

  // With a single-cycle memory, every access completes immediately.
  assign rdy = MEM_HS ? mem_ready : 1'b1;

  // State register; reset returns to FETCH from any state.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next;
  end

  // Retired-instruction counter; it wraps modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!reset_n)    instret <= '0;
    else if (retire) instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Next-state logic and Moore output decode, with the handshake gating.
  always_comb begin
    next      = state;
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 3'b000;
    ALUOp     = 2'b00;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (rdy) begin
          IRWrite   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 3'b010;
          PCUpdate  = 1'b1;
          next      = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_R:              next = S_EXECR;
          OP_I:              next = S_EXECI;
          OP_BR:             next = S_BRANCH;
          OP_JAL:            next = S_JAL;
          OP_JALR:           next = S_JALR;
          OP_LUI:            next = S_LUI;
          OP_AUIPC:          next = S_AUIPC;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          default:           next = S_TRAP;
`else
          default:           next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next    = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (rdy) next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 3'b001;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        next      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (rdy) begin
          MemWrite = 1'b1;
          retire   = 1'b1;
          next     = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        next    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        next    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
        retire  = 1'b1;
        next    = S_FETCH;
      end
      S_JAL: begin
        // The PC takes the target held in ALUOut. The ALU forms OldPC+4 for rd.
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
        next     = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next    = S_JAL;
      end
      S_LUI: begin
        ResultSrc = 3'b011;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        next      = S_FETCH;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        next    = S_ALUWB;
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: next = S_TRAP;
`endif
      default: next = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode, whatever the state.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE:          ImmSrc = 3'b001;
      OP_BR:             ImmSrc = 3'b010;
      OP_JAL:            ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC:  ImmSrc = 3'b100;
      default:           ImmSrc = 3'b000;
    endcase
  end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = (state == S_TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: this bench checks multicycle_ctrl one instruction at a time.
// For each instruction, the driver pushes an expected record. The record holds
// the cycle count, the per-cycle select trace, the strobe counts and positions,
// and the starting instret value. The monitor pops the record and compares the
// observed outputs against it.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  logic             clk, reset_n, mem_ready;
  logic [6:0]       op;
  logic             mem_req, AdrSrc, IRWrite, MemWrite, RegWrite, PCUpdate, Branch;
  logic [1:0]       ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0]       ResultSrc, ImmSrc;
  logic             retire, illegal_op;
  logic [CNT_W-1:0] instret;

  multicycle_ctrl #(.CNT_W(CNT_W), .MEM_HS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .PCUpdate(PCUpdate), .Branch(Branch),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUOp(ALUOp), .retire(retire), .instret(instret), .illegal_op(illegal_op)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #300000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_seq(input logic [6:0] o, input logic [175:0] act, input logic [175:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL sel_trace op=%h: got %h expected %h", o, act, exp);
    end
  endtask

  // Reference model: instruction classes and per-cycle select tuples.
  // Tuple layout: {ALUSrcA, ALUSrcB, ALUOp, ResultSrc, mem_req, AdrSrc}.
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5,
                 C_JALR = 6, C_LUI = 7, C_AUI = 8, C_ILL = 9;

  localparam logic [10:0] T_ZERO  = 11'b00_00_00_000_0_0;
  localparam logic [10:0] T_FWAIT = 11'b00_00_00_000_1_0;
  localparam logic [10:0] T_FRDY  = 11'b00_10_00_010_1_0;
  localparam logic [10:0] T_DEC   = 11'b01_01_00_000_0_0;
  localparam logic [10:0] T_EXR   = 11'b10_00_10_000_0_0;
  localparam logic [10:0] T_EXI   = 11'b10_01_10_000_0_0;
  localparam logic [10:0] T_ADR   = 11'b10_01_00_000_0_0;
  localparam logic [10:0] T_MEM   = 11'b00_00_00_000_1_1;
  localparam logic [10:0] T_MWB   = 11'b00_00_00_001_0_0;
  localparam logic [10:0] T_BR    = 11'b10_00_01_000_0_0;
  localparam logic [10:0] T_JAL   = 11'b01_10_00_000_0_0;
  localparam logic [10:0] T_LUI   = 11'b00_00_00_011_0_0;

  typedef struct {
    logic [6:0]       op;
    int               cycles;
    int               n_irw, n_pcu, n_rw, n_mw, n_br, n_ret, n_req;
    int               ret_pos, wr_pos;
    logic [CNT_W-1:0] instret0;
    logic [175:0]     seq;
  } exp_t;

  exp_t exp_q[$];

  function automatic int cls(input logic [6:0] o);
    case (o)
      7'h33: return C_R;
      7'h13: return C_I;
      7'h03: return C_LD;
      7'h23: return C_ST;
      7'h63: return C_BR;
      7'h6F: return C_JAL;
      7'h67: return C_JALR;
      7'h37: return C_LUI;
      7'h17: return C_AUI;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'h23: return 3'b001;
      7'h63: return 3'b010;
      7'h6F: return 3'b011;
      7'h37, 7'h17: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t build_exp(input logic [6:0] o, input int fw, input int mw,
                                     input logic [CNT_W-1:0] cnt);
    exp_t e;
    logic [10:0] t[$];
    int c;
    bit wr;
    c = cls(o);
    for (int i = 0; i < fw; i++) t.push_back(T_FWAIT);
    t.push_back(T_FRDY);
    t.push_back(T_DEC);
    case (c)
      C_R:    begin t.push_back(T_EXR); t.push_back(T_ZERO); end
      C_I:    begin t.push_back(T_EXI); t.push_back(T_ZERO); end
      C_LD:   begin
                t.push_back(T_ADR);
                for (int i = 0; i <= mw; i++) t.push_back(T_MEM);
                t.push_back(T_MWB);
              end
      C_ST:   begin
                t.push_back(T_ADR);
                for (int i = 0; i <= mw; i++) t.push_back(T_MEM);
              end
      C_BR:   t.push_back(T_BR);
      C_JAL:  begin t.push_back(T_JAL); t.push_back(T_ZERO); end
      C_JALR: begin t.push_back(T_ADR); t.push_back(T_JAL); t.push_back(T_ZERO); end
      C_LUI:  t.push_back(T_LUI);
      C_AUI:  begin t.push_back(T_DEC); t.push_back(T_ZERO); end
      default: ;
    endcase
    e.op       = o;
    e.cycles   = t.size();
    e.seq      = '0;
    for (int i = 0; i < t.size(); i++) e.seq[i*11 +: 11] = t[i];
    e.n_irw    = 1;
    e.n_pcu    = (c == C_JAL || c == C_JALR) ? 2 : 1;
    e.n_rw     = (c == C_R || c == C_I || c == C_LD || c == C_JAL || c == C_JALR ||
                  c == C_LUI || c == C_AUI) ? 1 : 0;
    e.n_mw     = (c == C_ST) ? 1 : 0;
    e.n_br     = (c == C_BR) ? 1 : 0;
    e.n_ret    = (c == C_ILL) ? 0 : 1;
    e.n_req    = fw + 1 + ((c == C_LD || c == C_ST) ? mw + 1 : 0);
    wr         = (e.n_rw + e.n_mw) > 0;
    e.ret_pos  = e.n_ret ? e.cycles - 1 : -1;
    e.wr_pos   = wr ? e.cycles - 1 : -1;
    e.instret0 = cnt;
    return e;
  endfunction

  // Driver. Inputs change 1 time unit after each rising edge.
  logic [CNT_W-1:0] model_cnt;

  task automatic run_instr(input logic [6:0] o, input int fw, input int mw);
    exp_t e;
    int c;
    e = build_exp(o, fw, mw, model_cnt);
    c = cls(o);
    exp_q.push_back(e);
    op = o;
    for (int i = 0; i < e.cycles; i++) begin
      if (i < fw)                                                   mem_ready = 1'b0;
      else if (i == fw)                                             mem_ready = 1'b1;
      else if ((c == C_LD || c == C_ST) && i >= fw + 3 && i < fw + 3 + mw) mem_ready = 1'b0;
      else if ((c == C_LD || c == C_ST) && i == fw + 3 + mw)        mem_ready = 1'b1;
      else                                                          mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    model_cnt = model_cnt + CNT_W'(e.n_ret);
  endtask

  // Monitor. It samples on the falling edge and compares whole instructions.
  bit           run_mon = 1'b0;
  bit           active  = 1'b0;
  exp_t         cur;
  int           idx;
  int           a_irw, a_pcu, a_rw, a_mw, a_br, a_ret, a_req, a_ill, a_imm_bad;
  int           a_ret_pos, a_wr_pos;
  logic [175:0] a_seq;

  always @(negedge clk) begin
    if (run_mon) begin
      if (!active && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        active = 1'b1;
        idx = 0;
        a_irw = 0; a_pcu = 0; a_rw = 0; a_mw = 0; a_br = 0; a_ret = 0; a_req = 0;
        a_ill = 0; a_imm_bad = 0; a_ret_pos = -1; a_wr_pos = -1; a_seq = '0;
      end
      if (active) begin
        if (idx == 0) check("instret_start", int'(instret), int'(cur.instret0));
        if (idx < 16) a_seq[idx*11 +: 11] = {ALUSrcA, ALUSrcB, ALUOp, ResultSrc, mem_req, AdrSrc};
        a_irw += int'(IRWrite);
        a_pcu += int'(PCUpdate);
        a_rw  += int'(RegWrite);
        a_mw  += int'(MemWrite);
        a_br  += int'(Branch);
        a_ret += int'(retire);
        a_req += int'(mem_req);
        a_ill += int'(illegal_op);
        if (ImmSrc !== imm_of(cur.op)) a_imm_bad++;
        if (retire) a_ret_pos = idx;
        if (RegWrite || MemWrite) a_wr_pos = idx;
        idx++;
        if (idx == cur.cycles) begin
          check_seq(cur.op, a_seq, cur.seq);
          check("IRWrite_count", a_irw, cur.n_irw);
          check("PCUpdate_count", a_pcu, cur.n_pcu);
          check("RegWrite_count", a_rw, cur.n_rw);
          check("MemWrite_count", a_mw, cur.n_mw);
          check("Branch_count", a_br, cur.n_br);
          check("retire_count", a_ret, cur.n_ret);
          check("mem_req_cycles", a_req, cur.n_req);
          check("retire_position", a_ret_pos, cur.ret_pos);
          check("write_position", a_wr_pos, cur.wr_pos);
          check("ImmSrc_bad_cycles", a_imm_bad, 0);
          check("illegal_op_cycles", a_ill, 0);
          active = 1'b0;
        end
      end
    end
  end

  // Stimulus sequence.
  logic [6:0] op_tab [10];

  initial begin
    int budget;
    op_tab = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    reset_n = 1'b0; op = 7'h33; mem_ready = 1'b0; model_cnt = '0;

    // Hold reset for two edges.
    @(posedge clk); @(posedge clk); #1;
    check("reset_mem_req", int'(mem_req), 1);
    check("reset_AdrSrc", int'(AdrSrc), 0);
    check("reset_instret", int'(instret), 0);
    check("reset_IRWrite", int'(IRWrite), 0);
    reset_n = 1'b1;
    run_mon = 1'b1;

    // Directed instructions: run_instr(opcode, fetch wait cycles, memory wait cycles).
    run_instr(7'h33, 2, 0);
    run_instr(7'h03, 0, 2);
    run_instr(7'h23, 1, 2);
    run_instr(7'h67, 0, 0);
    run_instr(7'h37, 0, 0);
    run_instr(7'h17, 1, 0);
    run_instr(7'h6F, 0, 0);
    run_instr(7'h63, 0, 0);
    run_instr(7'h13, 0, 0);
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    run_instr(7'h7F, 0, 0);
    run_instr(7'h00, 1, 0);
`endif
    // These 16 ALU instructions push instret past 15 so it wraps to 0.
    for (int i = 0; i < 16; i++) run_instr(7'h33, 0, 0);

    // Random instructions.
    for (int i = 0; i < 60; i++) begin
      int k;
      logic [6:0] o;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      k = $urandom_range(0, 8);
      o = op_tab[k];
`else
      k = $urandom_range(0, 10);
      if (k == 10) o = 7'($urandom_range(0, 127));
      else         o = op_tab[k];
`endif
      run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Wait for the monitor to drain. Bound the wait with a cycle budget.
    budget = 0;
    while ((active || exp_q.size() > 0) && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check("monitor_drained", int'(active || exp_q.size() > 0), 0);
    run_mon = 1'b0;

    // Reset while a load is waiting in MEMREAD.
    op = 7'h03; mem_ready = 1'b1;
    @(posedge clk); #1; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("memread_wait_req", int'(mem_req), 1);
    check("memread_wait_adr", int'(AdrSrc), 1);
    check("memread_wait_retire", int'(retire), 0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midwait_reset_req", int'(mem_req), 1);
    check("midwait_reset_adr", int'(AdrSrc), 0);
    check("midwait_reset_instret", int'(instret), 0);
    check("midwait_reset_irw", int'(IRWrite), 0);
    reset_n = 1'b1;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    // An illegal opcode locks the FSM in TRAP.
    op = 7'h7F; mem_ready = 1'b1;
    @(posedge clk); #1;
    check("decode_illegal_op", int'(illegal_op), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      check("trap_illegal_op", int'(illegal_op), 1);
      check("trap_strobes", int'({mem_req, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, retire}), 0);
      check("trap_instret", int'(instret), 0);
      @(posedge clk); #1;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
